// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core-wide constants for the fetch path
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int ROM_READ_LATENCY = 1;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, inst} pairs; head is the IF/ID register
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W = 2 * XLEN,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) mem_q[wr_q] <= din;
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
  assign count = count_q;
  assign head = mem_q[rd_q];
  // the issuer's credit check must make these unreachable
  assert property (@(posedge clk) disable iff (reset || flush)
    !(push && !pop && count_q == CW'(DEPTH)));
  assert property (@(posedge clk) disable iff (reset || flush)
    !(pop && count_q == '0));
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: issues ROM reads for pc_in, tags returned words with their pc
// and queues them for decode; credit-based back-pressure, flush on branch
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int DEPTH = 2,
  parameter logic [XLEN_P-1:0] NOP = XLEN_P'(NOP_INST)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [XLEN_P-1:0] pc_in,
  input  logic              branch,
  output logic [XLEN_P-1:0] rom_addr,
  output logic              rom_rd_en,
  input  logic [XLEN_P-1:0] rom_data,
  input  logic              id_stall,
  output logic              pc_stall,
  output logic              id_valid,
  output logic [XLEN_P-1:0] inst_to_decode,
  output logic [XLEN_P-1:0] pc_to_id
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic              req_valid_q, req_valid_d;
  logic [XLEN_P-1:0] req_pc_q, req_pc_d;
  logic [XLEN_P-1:0] last_pc_q;
  logic [CW-1:0]     count, occ;
  logic [2*XLEN_P-1:0] head;
  logic              pop, issue;
  always_comb begin
    id_valid = count != '0;
    pop = id_valid & ~id_stall & ~branch;
    // occupancy the queue will have once the in-flight word lands
    occ = count + CW'(req_valid_q) - CW'(pop);
    issue = ~reset & start & ~branch & (occ < CW'(DEPTH));
    pc_stall = ~reset & start & ~branch & ~issue;
    req_valid_d = issue;
    req_pc_d = issue ? pc_in : req_pc_q;
    rom_addr = pc_in;
    rom_rd_en = issue;
    inst_to_decode = id_valid ? head[XLEN_P-1:0] : NOP;
    pc_to_id = id_valid ? head[2*XLEN_P-1:XLEN_P] : last_pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid_q <= 1'b0;
      req_pc_q <= '0;
      last_pc_q <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_pc_q <= req_pc_d;
      if (id_valid) last_pc_q <= head[2*XLEN_P-1:XLEN_P];
    end
  end
  fetch_queue #(.DEPTH(DEPTH), .W(2 * XLEN_P)) u_queue (
    .clk(clk),
    .reset(reset),
    .flush(branch),
    .push(req_valid_q),
    .pop(pop),
    .din({req_pc_q, rom_data}),
    .count(count),
    .head(head)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage plus a randomized stall/branch
// stream checked for program order against a pc_register model and ROM image
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, start, branch, id_stall;
  logic [31:0] pc_in, rom_addr, rom_data, inst_to_decode, pc_to_id;
  logic        rom_rd_en, pc_stall, id_valid;
  logic [31:0] tgt;
  int          n_checks = 0, n_fail = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .branch(branch),
    .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_data(rom_data),
    .id_stall(id_stall), .pc_stall(pc_stall), .id_valid(id_valid),
    .inst_to_decode(inst_to_decode), .pc_to_id(pc_to_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_addr | 32'h100;

  always @(posedge clk)
    if (reset) pc_in <= '0;
    else if (branch) pc_in <= tgt;
    else if (start && !pc_stall) pc_in <= pc_in + 32'd4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_pc;
    int pops;
    reset = 1'b1; start = 1'b0; branch = 1'b0; id_stall = 1'b0; tgt = '0;
    step(); step(); #1;
    check("rst id_valid", 32'(id_valid), 0);
    check("rst inst", inst_to_decode, 32'h13);
    check("rst pc_to_id", pc_to_id, 0);
    check("rst rom_rd_en", 32'(rom_rd_en), 0);
    check("rst pc_stall", 32'(pc_stall), 0);
    reset = 1'b0; start = 1'b1; #1;
    check("t1 rd_en", 32'(rom_rd_en), 1);
    check("t1 addr", rom_addr, 0);
    step(); #1;
    check("t1 lat id_valid", 32'(id_valid), 0);
    step();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t1 id_valid", 32'(id_valid), 1);
      check("t1 pc", pc_to_id, 32'(4 * k));
      check("t1 inst", inst_to_decode, 32'(4 * k) | 32'h100);
      check("t1 pc_stall", 32'(pc_stall), 0);
      step();
    end
    id_stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("t2 pc_stall", 32'(pc_stall), 1);
      check("t2 head held", pc_to_id, 32'd16);
      step();
    end
    id_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2 id_valid", 32'(id_valid), 1);
      check("t2 pc", pc_to_id, 32'(16 + 4 * k));
      step();
    end
    tgt = 32'h40; branch = 1'b1; #1;
    check("t3 no issue", 32'(rom_rd_en), 0);
    check("t3 pc_stall", 32'(pc_stall), 0);
    step(); branch = 1'b0; #1;
    check("t3 id_valid", 32'(id_valid), 0);
    check("t3 nop", inst_to_decode, 32'h13);
    check("t3 pc hold", pc_to_id, 32'h20);
    check("t3 tgt issue", 32'(rom_rd_en), 1);
    check("t3 tgt addr", rom_addr, 32'h40);
    step(); #1;
    check("t3 lat", 32'(id_valid), 0);
    step(); #1;
    check("t3 tgt valid", 32'(id_valid), 1);
    check("t3 tgt pc", pc_to_id, 32'h40);
    check("t3 tgt inst", inst_to_decode, 32'h140);
    step(); #1;
    check("t3 next pc", pc_to_id, 32'h44);
    id_stall = 1'b1;
    step(); #1;
    check("t4 full stall", 32'(pc_stall), 1);
    tgt = 32'h80; branch = 1'b1;
    step(); branch = 1'b0; #1;
    check("t4 id_valid", 32'(id_valid), 0);
    check("t4 nop", inst_to_decode, 32'h13);
    check("t4 pc hold", pc_to_id, 32'h44);
    check("t4 tgt issue", 32'(rom_rd_en), 1);
    step(); step(); #1;
    check("t4 tgt pc", pc_to_id, 32'h80);
    step(); #1;
    check("t5 full", 32'(pc_stall), 1);
    reset = 1'b1;
    step(); #1;
    check("t5 id_valid", 32'(id_valid), 0);
    check("t5 inst", inst_to_decode, 32'h13);
    check("t5 pc_to_id", pc_to_id, 0);
    check("t5 rd_en", 32'(rom_rd_en), 0);
    check("t5 pc_stall", 32'(pc_stall), 0);
    reset = 1'b0; start = 1'b0; id_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      check("t5 drained", 32'(id_valid), 0);
      check("t5 idle", 32'(rom_rd_en), 0);
    end
    start = 1'b1; exp_pc = 0; pops = 0;
    for (int i = 0; i < 10000; i++) begin
      id_stall = ($urandom % 4) == 0;
      branch = ($urandom % 16) == 0;
      if (branch) tgt = 32'($urandom_range(0, 255)) << 2;
      #1;
      if (branch) exp_pc = tgt;
      else if (id_valid && !id_stall) begin
        check("t6 pc", pc_to_id, exp_pc);
        check("t6 inst", inst_to_decode, exp_pc | 32'h100);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      step();
    end
    check("t6 throughput", 32'(pops > 3000), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
